gddr6_rd_scheduler: RTL and testbench

- Per-channel GDDR6 read command scheduler. Sits between the controller front-end request port and the CA encoder, which is out of scope.
- Accepts one read request at a time (bank, row, column) and tracks open-row state for all 16 banks.
- Issues PREpb / ACT / RD in the order the row state requires, honouring tRP, tRAS, tRCD and tCCD_S/tCCD_L.
- Output stream must never trip the channel checker's RD-to-RD tCCD check.

---
 rtl/gddr6_pkg.sv | 61 ++++++
 rtl/gddr6_bank_timer.sv | 71 +++++++
 rtl/gddr6_rd_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_gddr6_rd_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gddr6_pkg.sv
// Shared definitions for the GDDR6 per-channel read scheduler: command codes,
// FSM states, bank-relationship codes, default timing and small helpers.
package gddr6_pkg;

    localparam int BANK_NUM = 16;
    localparam int BANK_W   = 4;

    localparam int ROW_W_DFLT = 15;
    localparam int COL_W_DFLT = 7;

    localparam int T_RCD_DFLT   = 12;
    localparam int T_RP_DFLT    = 12;
    localparam int T_RAS_DFLT   = 28;
    localparam int T_CCD_S_DFLT = 2;
    localparam int T_CCD_L_DFLT = 4;

    localparam int CMD_W = 5;
    localparam logic [CMD_W-1:0] CMD_NOP1  = 5'b00000;
    localparam logic [CMD_W-1:0] CMD_ACT   = 5'b00100;
    localparam logic [CMD_W-1:0] CMD_RD    = 5'b00101;
    localparam logic [CMD_W-1:0] CMD_PREPB = 5'b10000;

    typedef enum logic [1:0] {
        SAME_BANK  = 2'd0,
        DIFF_BANK  = 2'd1,
        SAME_GROUP = 2'd2,
        IGNORE     = 2'd3
    } bank_rel_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        WAIT_PRE = 3'd2,
        WAIT_ACT = 3'd3,
        WAIT_RD  = 3'd4
    } state_e;

    // Bank group is the top two bank bits; IGNORE when bank groups are disabled.
    function automatic bank_rel_e bank_rel(input logic [BANK_W-1:0] prev_bank,
                                           input logic [BANK_W-1:0] next_bank,
                                           input logic              bg_on);
        bank_rel_e rel;
        if (!bg_on) begin
            rel = IGNORE;
        end else if (prev_bank == next_bank) begin
            rel = SAME_BANK;
        end else if (prev_bank[BANK_W-1:BANK_W-2] == next_bank[BANK_W-1:BANK_W-2]) begin
            rel = SAME_GROUP;
        end else begin
            rel = DIFF_BANK;
        end
        return rel;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gddr6_bank_timer.sv
// One bank's open-row state and its tRAS / tRP / tRCD down-counters.
// A counter loaded with L at edge n reads zero in time for the dependent command at edge n+L+1.
module gddr6_bank_timer
    import gddr6_pkg::*;
#(
    parameter int ROW_W = ROW_W_DFLT,
    parameter int T_RCD = T_RCD_DFLT,
    parameter int T_RP  = T_RP_DFLT,
    parameter int T_RAS = T_RAS_DFLT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_pre,
    input  logic             load_act,
    input  logic [ROW_W-1:0] act_row,
    output logic             is_open,
    output logic [ROW_W-1:0] open_row,
    output logic             pre_ready,
    output logic             act_ready,
    output logic             rd_ready
);
    localparam int CNT_W = $clog2(max3(T_RCD, T_RP, T_RAS));

    logic [CNT_W-1:0] ras_cnt_r;
    logic [CNT_W-1:0] rp_cnt_r;
    logic [CNT_W-1:0] rcd_cnt_r;
    logic             open_r;
    logic [ROW_W-1:0] open_row_r;

    // Open-page bookkeeping: ACT opens the bank with its row, PREpb closes it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            open_r     <= 1'b0;
            open_row_r <= '0;
        end else if (load_act) begin
            open_r     <= 1'b1;
            open_row_r <= act_row;
        end else if (load_pre) begin
            open_r     <= 1'b0;
        end
    end

    // Saturating timing counters, reloaded by the command they constrain from.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ras_cnt_r <= '0;
            rp_cnt_r  <= '0;
            rcd_cnt_r <= '0;
        end else begin
            if (load_act) begin
                ras_cnt_r <= CNT_W'(T_RAS - 1);
                rcd_cnt_r <= CNT_W'(T_RCD - 1);
            end else begin
                if (ras_cnt_r != '0) ras_cnt_r <= ras_cnt_r - CNT_W'(1);
                if (rcd_cnt_r != '0) rcd_cnt_r <= rcd_cnt_r - CNT_W'(1);
            end
            if (load_pre) begin
                rp_cnt_r <= CNT_W'(T_RP - 1);
            end else if (rp_cnt_r != '0) begin
                rp_cnt_r <= rp_cnt_r - CNT_W'(1);
            end
        end
    end

    assign is_open   = open_r;
    assign open_row  = open_row_r;
    assign pre_ready = (ras_cnt_r == '0);
    assign act_ready = (rp_cnt_r == '0);
    assign rd_ready  = (rcd_cnt_r == '0);

endmodule

// File: rtl/gddr6_rd_scheduler.sv
// Per-channel GDDR6 read scheduler: one request at a time, open-page policy,
// issues PREpb / ACT / RD honouring tRAS, tRP, tRCD and tCCD_S / tCCD_L.
module gddr6_rd_scheduler
    import gddr6_pkg::*;
#(
    parameter int ROW_W   = ROW_W_DFLT,
    parameter int COL_W   = COL_W_DFLT,
    parameter int T_RCD   = T_RCD_DFLT,
    parameter int T_RP    = T_RP_DFLT,
    parameter int T_RAS   = T_RAS_DFLT,
    parameter int T_CCD_S = T_CCD_S_DFLT,
    parameter int T_CCD_L = T_CCD_L_DFLT
) (
    input  logic              CLK_t,
    input  logic              RESET_n,
    input  logic              bg_en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [COL_W-1:0]  req_col,
    output logic              cmd_valid,
    output logic [CMD_W-1:0]  cmd,
    output logic [BANK_W-1:0] cmd_bank,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [COL_W-1:0]  cmd_col
);
    localparam int CCD_W = $clog2(T_CCD_L + 1);

    state_e              state_r;
    state_e              state_nx_s;
    logic [BANK_W-1:0]   bank_r;
    logic [ROW_W-1:0]    row_r;
    logic [COL_W-1:0]    col_r;
    logic                accept_s;

    logic [BANK_NUM-1:0] open_s;
    logic [BANK_NUM-1:0] pre_ready_s;
    logic [BANK_NUM-1:0] act_ready_s;
    logic [BANK_NUM-1:0] rd_ready_s;
    logic [BANK_NUM-1:0] load_pre_s;
    logic [BANK_NUM-1:0] load_act_s;
    logic [ROW_W-1:0]    open_row_s [BANK_NUM];

    logic [CCD_W-1:0]    ccd_cnt_r;
    logic [CCD_W-1:0]    ccd_elapsed_r;
    logic [BANK_W-1:0]   last_rd_bank_r;
    bank_rel_e           rd_rel_s;
    logic                ccd_ok_s;

    logic                issue_pre_s;
    logic                issue_act_s;
    logic                issue_rd_s;
    logic [CMD_W-1:0]    cmd_nx_s;
    logic [BANK_W-1:0]   cmd_bank_nx_s;
    logic [ROW_W-1:0]    cmd_row_nx_s;
    logic [COL_W-1:0]    cmd_col_nx_s;

    assign req_ready = (state_r == IDLE) && RESET_n;
    assign accept_s  = req_valid && req_ready;

    for (genvar i = 0; i < BANK_NUM; i++) begin : g_bank
        assign load_pre_s[i] = issue_pre_s && (bank_r == BANK_W'(i));
        assign load_act_s[i] = issue_act_s && (bank_r == BANK_W'(i));

        gddr6_bank_timer #(
            .ROW_W (ROW_W),
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS)
        ) u_timer (
            .clk       (CLK_t),
            .reset_n   (RESET_n),
            .load_pre  (load_pre_s[i]),
            .load_act  (load_act_s[i]),
            .act_row   (row_r),
            .is_open   (open_s[i]),
            .open_row  (open_row_s[i]),
            .pre_ready (pre_ready_s[i]),
            .act_ready (act_ready_s[i]),
            .rd_ready  (rd_ready_s[i])
        );
    end

    // tCCD_L only applies when bank groups are on and the next RD stays in the last RD's group.
    assign rd_rel_s = bank_rel(last_rd_bank_r, bank_r, bg_en);
    assign ccd_ok_s = (ccd_cnt_r == '0) &&
                      (((rd_rel_s != SAME_BANK) && (rd_rel_s != SAME_GROUP)) ||
                       (ccd_elapsed_r >= CCD_W'(T_CCD_L)));

    // FSM state register.
    always_ff @(posedge CLK_t) begin
        if (!RESET_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nx_s = CHECK;
                else          state_nx_s = IDLE;
            end
            CHECK: begin
                if (open_s[bank_r] && (open_row_s[bank_r] == row_r)) state_nx_s = WAIT_RD;
                else if (open_s[bank_r])                             state_nx_s = WAIT_PRE;
                else                                                 state_nx_s = WAIT_ACT;
            end
            WAIT_PRE: begin
                if (pre_ready_s[bank_r]) state_nx_s = WAIT_ACT;
                else                     state_nx_s = WAIT_PRE;
            end
            WAIT_ACT: begin
                if (act_ready_s[bank_r]) state_nx_s = WAIT_RD;
                else                     state_nx_s = WAIT_ACT;
            end
            WAIT_RD: begin
                if (rd_ready_s[bank_r] && ccd_ok_s) state_nx_s = IDLE;
                else                                state_nx_s = WAIT_RD;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM outputs: command issue strobes and the next registered command fields.
    always_comb begin
        issue_pre_s = 1'b0;
        issue_act_s = 1'b0;
        issue_rd_s  = 1'b0;
        case (state_r)
            WAIT_PRE: issue_pre_s = pre_ready_s[bank_r];
            WAIT_ACT: issue_act_s = act_ready_s[bank_r];
            WAIT_RD:  issue_rd_s  = rd_ready_s[bank_r] && ccd_ok_s;
            default: begin
                issue_pre_s = 1'b0;
                issue_act_s = 1'b0;
                issue_rd_s  = 1'b0;
            end
        endcase

        cmd_nx_s      = CMD_NOP1;
        cmd_bank_nx_s = '0;
        cmd_row_nx_s  = '0;
        cmd_col_nx_s  = '0;
        if (issue_pre_s) begin
            cmd_nx_s      = CMD_PREPB;
            cmd_bank_nx_s = bank_r;
        end else if (issue_act_s) begin
            cmd_nx_s      = CMD_ACT;
            cmd_bank_nx_s = bank_r;
            cmd_row_nx_s  = row_r;
        end else if (issue_rd_s) begin
            cmd_nx_s      = CMD_RD;
            cmd_bank_nx_s = bank_r;
            cmd_col_nx_s  = col_r;
        end else begin
            cmd_nx_s      = CMD_NOP1;
        end
    end

    // Request capture on the accepting edge.
    always_ff @(posedge CLK_t) begin
        if (!RESET_n) begin
            bank_r <= '0;
            row_r  <= '0;
            col_r  <= '0;
        end else if (accept_s) begin
            bank_r <= req_bank;
            row_r  <= req_row;
            col_r  <= req_col;
        end
    end

    // RD-to-RD spacing: short-gap down-counter plus an elapsed counter for the same-group gap.
    always_ff @(posedge CLK_t) begin
        if (!RESET_n) begin
            ccd_cnt_r      <= '0;
            ccd_elapsed_r  <= CCD_W'(T_CCD_L);
            last_rd_bank_r <= '0;
        end else if (issue_rd_s) begin
            ccd_cnt_r      <= CCD_W'(T_CCD_S - 1);
            ccd_elapsed_r  <= CCD_W'(1);
            last_rd_bank_r <= bank_r;
        end else begin
            if (ccd_cnt_r != '0) ccd_cnt_r <= ccd_cnt_r - CCD_W'(1);
            if (ccd_elapsed_r < CCD_W'(T_CCD_L)) ccd_elapsed_r <= ccd_elapsed_r + CCD_W'(1);
        end
    end

    // Registered command outputs.
    always_ff @(posedge CLK_t) begin
        if (!RESET_n) begin
            cmd_valid <= 1'b0;
            cmd       <= CMD_NOP1;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
        end else begin
            cmd_valid <= issue_pre_s || issue_act_s || issue_rd_s;
            cmd       <= cmd_nx_s;
            cmd_bank  <= cmd_bank_nx_s;
            cmd_row   <= cmd_row_nx_s;
            cmd_col   <= cmd_col_nx_s;
        end
    end

endmodule

// File: tb/tb_gddr6_rd_scheduler.sv
// Randomized bench for gddr6_rd_scheduler: a timing-rule model predicts the cycle,
// code, bank and address of every command; a monitor matches the DUT stream.
module tb_gddr6_rd_scheduler;
    import gddr6_pkg::*;

    localparam int ROW_W   = 15;
    localparam int COL_W   = 7;
    localparam int T_RCD   = 12;
    localparam int T_RP    = 12;
    localparam int T_RAS   = 28;
    localparam int T_CCD_S = 2;
    localparam int T_CCD_L = 4;
    localparam int NEVER   = -1000;

    logic             CLK_t = 1'b0;
    logic             RESET_n = 1'b0;
    logic             bg_en = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_bank = 4'd0;
    logic [ROW_W-1:0] req_row = '0;
    logic [COL_W-1:0] req_col = '0;
    logic             cmd_valid;
    logic [4:0]       cmd;
    logic [3:0]       cmd_bank;
    logic [ROW_W-1:0] cmd_row;
    logic [COL_W-1:0] cmd_col;

    gddr6_rd_scheduler #(
        .ROW_W(ROW_W), .COL_W(COL_W), .T_RCD(T_RCD), .T_RP(T_RP),
        .T_RAS(T_RAS), .T_CCD_S(T_CCD_S), .T_CCD_L(T_CCD_L)
    ) dut (
        .CLK_t(CLK_t), .RESET_n(RESET_n), .bg_en(bg_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_bank(req_bank),
        .req_row(req_row), .req_col(req_col),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col)
    );

    always #5 CLK_t = ~CLK_t;

    // Edge counter: after rising edge n, cyc == n.
    int cyc = 0;
    always @(posedge CLK_t) cyc <= cyc + 1;

    typedef struct {
        int               t;
        logic [4:0]       code;
        logic [3:0]       bank;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   abort = 1'b0;

    bit   m_open [16];
    int   m_row  [16];
    int   m_act  [16];
    int   m_pre  [16];
    int   m_rd;
    bit   m_rd_seen;
    int   m_bg;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = 0;
            m_act[i]  = NEVER;
            m_pre[i]  = NEVER;
        end
        m_rd      = NEVER;
        m_rd_seen = 1'b0;
        m_bg      = 0;
    endtask

    task automatic push_exp(input int t, input logic [4:0] code, input logic [3:0] b,
                            input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        exp_t e;
        e.t = t; e.code = code; e.bank = b; e.row = r; e.col = c;
        exp_q.push_back(e);
    endtask

    // Earliest legal issue edge of each command for a request accepted at edge e.
    task automatic predict(input int e, input logic [3:0] b,
                           input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        int t_pre, t_act, t_rd;
        if (m_open[b] && m_row[b] == int'(r)) begin
            t_rd = imax(e + 2, m_act[b] + T_RCD);
        end else begin
            if (m_open[b]) begin
                t_pre = imax(e + 2, m_act[b] + T_RAS);
                push_exp(t_pre, CMD_PREPB, b, '0, '0);
                m_pre[b] = t_pre;
                t_act = t_pre + T_RP;
            end else begin
                t_act = imax(e + 2, m_pre[b] + T_RP);
            end
            push_exp(t_act, CMD_ACT, b, r, '0);
            m_act[b]  = t_act;
            m_open[b] = 1'b1;
            m_row[b]  = int'(r);
            t_rd = t_act + T_RCD;
        end
        if (m_rd_seen) begin
            t_rd = imax(t_rd, m_rd + T_CCD_S);
            if (bg_en && m_bg == int'(b[3:2])) t_rd = imax(t_rd, m_rd + T_CCD_L);
        end
        push_exp(t_rd, CMD_RD, b, '0, c);
        m_rd      = t_rd;
        m_rd_seen = 1'b1;
        m_bg      = int'(b[3:2]);
    endtask

    // Hold req_valid with junk while not ready; present the real request once ready.
    task automatic send(input logic [3:0] b, input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        int waited = 0;
        if (abort) return;
        @(negedge CLK_t);
        while (req_ready !== 1'b1 && waited < 300) begin
            req_valid = 1'b1;
            req_bank  = 4'($urandom);
            req_row   = ROW_W'($urandom);
            req_col   = COL_W'($urandom);
            waited++;
            @(negedge CLK_t);
        end
        if (req_ready !== 1'b1) begin
            check_val("req_ready_timeout", 64'(req_ready), 64'd1);
            abort     = 1'b1;
            req_valid = 1'b0;
            return;
        end
        req_valid = 1'b1;
        req_bank  = b;
        req_row   = r;
        req_col   = c;
        predict(cyc + 1, b, r, c);
        @(posedge CLK_t);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(negedge CLK_t);
            n++;
        end
        check_val("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        check_val({tag, "_cmd"},       64'(cmd), 64'(CMD_NOP1));
        check_val({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check_val({tag, "_cmd_bank"},  64'(cmd_bank), 64'd0);
        check_val({tag, "_cmd_row"},   64'(cmd_row), 64'd0);
        check_val({tag, "_cmd_col"},   64'(cmd_col), 64'd0);
    endtask

    initial begin
        model_reset();
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge CLK_t);
                    if (RESET_n === 1'b1) begin
                        if (cmd_valid === 1'b1) begin
                            if (exp_q.size() == 0) begin
                                check_val("spurious_cmd", 64'(cmd_valid), 64'd0);
                            end else begin
                                e = exp_q.pop_front();
                                check_val("cmd_code", 64'(cmd), 64'(e.code));
                                check_val("cmd_bank", 64'(cmd_bank), 64'(e.bank));
                                check_val("cmd_cycle", 64'(cyc), 64'(e.t));
                                if (e.code == CMD_ACT) check_val("act_row", 64'(cmd_row), 64'(e.row));
                                if (e.code == CMD_RD)  check_val("rd_col", 64'(cmd_col), 64'(e.col));
                            end
                        end else begin
                            check_val("idle_code", 64'(cmd), 64'(CMD_NOP1));
                            if (exp_q.size() > 0 && exp_q[0].t < cyc) begin
                                e = exp_q.pop_front();
                                check_val("missing_cmd_cycle", 64'(cyc), 64'(e.t));
                            end
                        end
                    end
                end
            end
            begin : main
                // Reset with a request waving at the port; nothing may be accepted.
                req_valid = 1'b1;
                req_bank  = 4'd7;
                repeat (3) @(negedge CLK_t);
                check_reset_outputs("por");
                RESET_n   = 1'b1;
                req_valid = 1'b0;

                // Closed bank, then a hit (tCCD_L), then a miss.
                bg_en = 1'b1;
                send(4'd3, 15'h0123, 7'd5);
                send(4'd3, 15'h0123, 7'd6);
                send(4'd3, 15'h0200, 7'd7);

                // Hits across groups (spacing 3) then within a group (spacing 4).
                send(4'd0, 15'h0001, 7'd0);
                send(4'd4, 15'h0002, 7'd0);
                send(4'd5, 15'h0003, 7'd0);
                send(4'd0, 15'h0001, 7'd1);
                send(4'd4, 15'h0002, 7'd1);
                send(4'd5, 15'h0003, 7'd1);
                drain();

                // Bank groups off: same-group hits only need tCCD_S.
                bg_en = 1'b0;
                send(4'd5, 15'h0003, 7'd2);
                send(4'd4, 15'h0002, 7'd2);

                // Miss on bank 3, then reset while it waits to activate.
                send(4'd3, 15'h0300, 7'd8);
                while (!abort && cyc < m_pre[3] + 3) @(negedge CLK_t);
                RESET_n   = 1'b0;
                req_valid = 1'b1;
                req_bank  = 4'd3;
                repeat (2) @(negedge CLK_t);
                check_reset_outputs("mid_reset");
                exp_q.delete();
                model_reset();
                RESET_n   = 1'b1;
                req_valid = 1'b0;
                repeat (20) @(negedge CLK_t);
                send(4'd3, 15'h0300, 7'd9);

                // Randomized traffic over a few rows so hits, misses and closed banks all occur.
                for (int n = 0; n < 150 && !abort; n++) begin
                    if (n % 50 == 0) begin
                        drain();
                        bg_en = 1'($urandom_range(0, 1));
                    end
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge CLK_t);
                    send(4'($urandom_range(0, 15)), ROW_W'($urandom_range(0, 3)), COL_W'($urandom));
                end
                drain();
                repeat (5) @(negedge CLK_t);
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
